// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step move controller and its period timer.
package step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } step_state_e;

   localparam int   MIN_PERIOD = 2;
   localparam logic CW         = 1'b0;
   localparam logic CCW        = 1'b1;

endpackage

// File: rtl/step_move_controller_if.sv
// Move command channel: valid/ready handshake with step count, direction, period, plus abort.
interface step_move_controller_if #(
   parameter int STEP_W   = 16,
   parameter int PERIOD_W = 20
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [STEP_W-1:0]   cmd_steps;
   logic                cmd_dir;
   logic [PERIOD_W-1:0] cmd_period;
   logic                abort;

   modport master (
      output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      output cmd_ready
   );
endinterface

// File: rtl/step_period_timer.sv
// Loadable down-counter giving a one-cycle expire strobe one interval after each load.
// With STEP_RAMP_EN defined the interval ramps down from RAMP_START toward the commanded period.
module step_period_timer #(
   parameter int PERIOD_W = 20
`ifdef STEP_RAMP_EN
   ,
   parameter int RAMP_START = 50000,
   parameter int RAMP_DEC   = 1000
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
`ifdef STEP_RAMP_EN
   input  logic                first_i,
`endif
   input  logic [PERIOD_W-1:0] period_i,
   output logic                expire_o
);

   logic [PERIOD_W-1:0] interval;
   logic [PERIOD_W-1:0] cnt_q;
   logic                armed_q;

`ifdef STEP_RAMP_EN
   localparam logic [PERIOD_W-1:0] RS = PERIOD_W'(RAMP_START);
   localparam logic [PERIOD_W:0]   RD = (PERIOD_W+1)'(RAMP_DEC);

   logic [PERIOD_W-1:0] ramp_q;
   logic [PERIOD_W:0]   floor_w;

   // Extra bit on the floor compare so period + RAMP_DEC cannot overflow.
   always_comb begin
      floor_w = {1'b0, period_i} + RD;
      if (first_i)
         interval = (period_i >= RS) ? period_i : RS;
      else if ({1'b0, ramp_q} > floor_w)
         interval = ramp_q - RD[PERIOD_W-1:0];
      else
         interval = period_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ramp_q <= '0;
      else if (load_i)
         ramp_q <= interval;
   end
`else
   assign interval = period_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else if (load_i) begin
         cnt_q   <= interval - 1'b1;
         armed_q <= 1'b1;
      end else if (cnt_q != '0) begin
         cnt_q   <= cnt_q - 1'b1;
      end else begin
         armed_q <= 1'b0;
      end
   end

   assign expire_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/step_move_controller.sv
// Step sequencer: accepts move commands and emits one registered step pulse per step,
// with a direction setup interval before the first pulse. Ramp option: STEP_RAMP_EN.
//
//   state    | meaning
//   ST_IDLE  | cmd_ready high, waiting for a command
//   ST_SETUP | dir driven, counting DIR_SETUP cycles before the first pulse
//   ST_RUN   | issuing pulses on timer expiry until steps_left reaches 0
//   ST_DONE  | one-cycle done strobe, then back to idle
module step_move_controller
   import step_ctrl_pkg::*;
#(
   parameter int STEP_W    = 16,
   parameter int PERIOD_W  = 20,
   parameter int DIR_SETUP = 4
`ifdef STEP_RAMP_EN
   ,
   parameter int RAMP_START = 50000,
   parameter int RAMP_DEC   = 1000
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   step_move_controller_if.slave cmd,
   output logic              step_pulse,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] steps_left
);

   localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
   localparam logic [SETUP_W-1:0] SETUP_INIT = SETUP_W'(DIR_SETUP - 1);

   step_state_e          state_q;
   logic                 cmd_ready_q;
   logic                 step_pulse_q;
   logic                 dir_q;
   logic                 busy_q;
   logic                 done_q;
   logic [STEP_W-1:0]    steps_left_q;
   logic [PERIOD_W-1:0]  period_q;
   logic [SETUP_W-1:0]   setup_cnt_q;

   logic                 accept;
   logic                 fire;
   logic                 tmr_expire;
   logic [PERIOD_W-1:0]  period_clamped;

   assign accept         = (state_q == ST_IDLE) && cmd_ready_q && cmd.cmd_valid;
   assign period_clamped = (cmd.cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                    : cmd.cmd_period;

   // Abort has priority over a pulse that would fire on the same edge.
   assign fire = !cmd.abort &&
                 (((state_q == ST_SETUP) && (setup_cnt_q == '0)) ||
                  ((state_q == ST_RUN) && (steps_left_q != '0) && tmr_expire));

   step_period_timer #(
      .PERIOD_W   (PERIOD_W)
`ifdef STEP_RAMP_EN
      ,
      .RAMP_START (RAMP_START),
      .RAMP_DEC   (RAMP_DEC)
`endif
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (fire),
`ifdef STEP_RAMP_EN
      .first_i  (state_q == ST_SETUP),
`endif
      .period_i (period_q),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b0;
         step_pulse_q <= 1'b0;
         dir_q        <= CW;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         steps_left_q <= '0;
         period_q     <= PERIOD_W'(MIN_PERIOD);
         setup_cnt_q  <= '0;
      end else begin
         step_pulse_q <= fire;
         done_q       <= 1'b0;
         if (fire)
            steps_left_q <= steps_left_q - 1'b1;

         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (accept) begin
                  cmd_ready_q  <= 1'b0;
                  dir_q        <= cmd.cmd_dir;
                  period_q     <= period_clamped;
                  steps_left_q <= cmd.cmd_steps;
                  if (cmd.cmd_steps == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= ST_SETUP;
                     busy_q      <= 1'b1;
                     setup_cnt_q <= SETUP_INIT;
                  end
               end
            end
            ST_SETUP: begin
               if (cmd.abort) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (setup_cnt_q == '0) begin
                  state_q <= ST_RUN;
               end else begin
                  setup_cnt_q <= setup_cnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (cmd.abort || (steps_left_q == '0)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign step_pulse    = step_pulse_q;
   assign dir           = dir_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign steps_left    = steps_left_q;

endmodule

// File: tb/tb_step_move_controller.sv
// Bench for step_move_controller: directed and random moves checked against pulse-time arithmetic.
module tb_step_move_controller;
   import step_ctrl_pkg::*;

   localparam int STEP_W    = 16;
   localparam int PERIOD_W  = 20;
   localparam int DS        = 4;
`ifdef STEP_RAMP_EN
   localparam int TB_RS     = 20;
   localparam int TB_RD     = 5;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              step_pulse, dir, busy, done;
   logic [STEP_W-1:0] steps_left;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int   pulse_t[$];
   int   done_t[$];
   int   done_left = -1;
   int   dir_viol  = 0;
   logic prev_busy = 1'b0;
   logic prev_dir  = 1'b0;
   logic last_dir  = CW;

   step_move_controller_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) cif ();

   step_move_controller #(
      .STEP_W    (STEP_W),
      .PERIOD_W  (PERIOD_W),
      .DIR_SETUP (DS)
`ifdef STEP_RAMP_EN
      ,
      .RAMP_START(TB_RS),
      .RAMP_DEC  (TB_RD)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cif),
      .step_pulse (step_pulse),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (step_pulse) pulse_t.push_back(cyc);
         if (done) begin
            done_t.push_back(cyc);
            done_left = int'(steps_left);
         end
         if (busy && prev_busy && (dir !== prev_dir)) dir_viol++;
      end
      prev_busy = busy;
      prev_dir  = dir;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Interval between pulse k and pulse k+1, straight from the rate rules.
   function automatic int interval(input int k, input int per);
`ifdef STEP_RAMP_EN
      int iv;
      if (per >= TB_RS) return per;
      iv = TB_RS - (k - 1) * TB_RD;
      return (iv < per) ? per : iv;
`else
      return (k > 0) ? per : per;
`endif
   endfunction

   // ab_off < 0: no abort; otherwise abort is driven high during cycle acc+ab_off.
   task automatic do_move(input string name, input int steps, input logic d,
                          input int per, input int ab_off);
      int acc, eff, t, last, exp_done, exp_left, waited, n;
      int exp_p[$];
      waited = 0;
      while (cif.cmd_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_ready_wait"}, cif.cmd_ready, 1);
      if (cif.cmd_ready !== 1'b1) return;
      check({name, "_dir_held"}, dir, last_dir);
      pulse_t.delete();
      done_t.delete();
      done_left = -1;
      acc = cyc;
      cif.cmd_valid  = 1'b1;
      cif.cmd_steps  = STEP_W'(steps);
      cif.cmd_dir    = d;
      cif.cmd_period = PERIOD_W'(per);
      cif.abort      = (ab_off == 0);

      eff  = (per < MIN_PERIOD) ? MIN_PERIOD : per;
      t    = acc + 1 + DS;
      last = acc;
      for (int k = 1; k <= steps; k++) begin
         exp_p.push_back(t);
         last = t;
         t += interval(k, eff);
      end
      exp_done = (steps == 0) ? acc + 1 : last + 1;
      if (steps > 0 && ab_off >= 1 && acc + ab_off <= last) begin
         while (exp_p.size() > 0 && exp_p[$] > acc + ab_off) void'(exp_p.pop_back());
         exp_done = acc + ab_off + 1;
      end
      exp_left = steps - exp_p.size();

      while (cyc < exp_done + 1) begin
         @(negedge clk);
         cif.cmd_valid = 1'b0;
         cif.abort     = (ab_off >= 1) && (cyc == acc + ab_off);
         if (cyc == acc + 1) begin
            check({name, "_dir"}, dir, d);
            check({name, "_busy"}, busy, (steps > 0) ? 1 : 0);
         end
         if (cyc == exp_done) check({name, "_ready_in_done"}, cif.cmd_ready, 0);
      end
      cif.abort = 1'b0;
      check({name, "_ready_after"}, cif.cmd_ready, 1);
      check({name, "_busy_after"}, busy, 0);
      check({name, "_pulse_count"}, pulse_t.size(), exp_p.size());
      n = (pulse_t.size() < exp_p.size()) ? pulse_t.size() : exp_p.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_pulse%0d_time", name, i + 1), pulse_t[i] - acc, exp_p[i] - acc);
      check({name, "_done_count"}, done_t.size(), 1);
      if (done_t.size() > 0) check({name, "_done_time"}, done_t[0] - acc, exp_done - acc);
      check({name, "_steps_left"}, done_left, exp_left);
      last_dir = d;
   endtask

   initial begin
      int st, pr, ab;
      logic dd;
      cif.cmd_valid  = 1'b0;
      cif.cmd_steps  = '0;
      cif.cmd_dir    = 1'b0;
      cif.cmd_period = '0;
      cif.abort      = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", cif.cmd_ready, 0);
      check("rst_pulse", step_pulse, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_steps_left", steps_left, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", cif.cmd_ready, 1);
      check("post_rst_pulse", step_pulse, 0);

      cif.abort = 1'b1;
      repeat (3) @(negedge clk);
      cif.abort = 1'b0;
      check("idle_abort_ready", cif.cmd_ready, 1);
      check("idle_abort_done_seen", done_t.size(), 0);

      do_move("basic",      3,   1'b1, 10, -1);
      do_move("zero",       0,   1'b0, 5,  -1);
      do_move("abort_p5",   100, 1'b1, 8,  36);
      do_move("per0",       5,   1'b0, 0,  -1);
      do_move("b2b_a",      4,   1'b1, 1,  -1);
      do_move("b2b_b",      4,   1'b0, 3,  -1);
      do_move("abort_setup",6,   1'b1, 5,  2);
      do_move("abort_w_cmd",2,   1'b0, 3,  0);
      do_move("ramp",       5,   1'b0, 8,  -1);

      for (int i = 0; i < 20; i++) begin
         st = $urandom_range(0, 6);
         pr = $urandom_range(0, 12);
         dd = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
         do_move($sformatf("rnd%0d", i), st, dd, pr, ab);
      end

      check("dir_stable_while_busy", dir_viol, 0);

      // Reset in the middle of a move.
      cif.cmd_valid = 1'b1; cif.cmd_steps = 16'd50; cif.cmd_dir = 1'b1; cif.cmd_period = 20'd4;
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_pulse", step_pulse, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_dir", dir, 0);
      check("mid_rst_steps_left", steps_left, 0);
      check("mid_rst_ready", cif.cmd_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_t.delete();
      repeat (3) @(negedge clk);
      check("mid_rst_ready_after", cif.cmd_ready, 1);
      check("mid_rst_no_pulse", pulse_t.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
